// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl -- block-mode controller sitting between a host stream and an
// iterative AES core. Handles key setup, one block in flight at a time, and
// CBC chaining around the core.
//
// Build option: define AES_CBC_CTRL_CBC_EN to enable CBC chaining. Without it
// the controller runs ECB: no chain register, iv/iv_load have no effect.
//
// Handshakes: a transfer happens on a stream port in the cycle where valid and
// ready are both high at the rising clock edge; valid, once raised, holds its
// data stable until that transfer, and ready never depends on a later cycle.
module aes_cbc_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   // host control
   input  logic [255:0] key,
   input  logic [1:0]   key_mode,
   input  logic         key_load,
   input  logic [127:0] iv,
   input  logic         iv_load,
   input  logic         enc,
   // input block stream
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [127:0] s_data,
   // output block stream
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   // AES core
   output logic [255:0] core_key,
   output logic [1:0]   core_mode,
   output logic         core_enc,
   output logic         core_keygen,
   output logic         core_run,
   output logic [127:0] core_in,
   input  logic [127:0] core_out,
   input  logic         core_ready,
   input  logic         core_done,
   // status / debug
   output logic         key_valid,
   output logic         busy,
   output logic [2:0]   state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      KEYGEN = 3'd1,
      KWAIT  = 3'd2,
      LOAD   = 3'd3,
      CWAIT  = 3'd4,
      OUT    = 3'd5
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [127:0] in_reg;
   logic         enc_reg;
   logic         key_go;
   logic         accept;
   logic         kick;
   logic         done_ok;

`ifdef AES_CBC_CTRL_CBC_EN
   logic [127:0] chain;
   logic         iv_go;
`else
   logic         unused_iv;
   assign unused_iv = ^{iv, iv_load};
`endif

   assign state_dbg = state_q;

   // A done seen while our own run pulse is still high cannot belong to it.
   assign done_ok = core_done && !core_run;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode plus host handshake and core kick strobes.
   always_comb begin
      state_d = state_q;
      key_go  = 1'b0;
      accept  = 1'b0;
      kick    = 1'b0;
      s_ready = 1'b0;
      busy    = (state_q != IDLE);
`ifdef AES_CBC_CTRL_CBC_EN
      iv_go   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            key_go  = key_load;
`ifdef AES_CBC_CTRL_CBC_EN
            iv_go   = iv_load;
            s_ready = key_valid && !key_load && !iv_load;
`else
            s_ready = key_valid && !key_load;
`endif
            accept  = s_valid && s_ready;
            if (key_go)      state_d = KEYGEN;
            else if (accept) state_d = LOAD;
         end
         KEYGEN: begin
            kick = core_ready;
            if (core_ready) state_d = KWAIT;
         end
         KWAIT: begin
            if (done_ok) state_d = IDLE;
         end
         LOAD: begin
            kick = core_ready;
            if (core_ready) state_d = CWAIT;
         end
         CWAIT: begin
            if (done_ok) state_d = OUT;
         end
         OUT: begin
            // m_valid is always high in OUT, so m_ready alone completes it.
            if (m_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Key registers, key-expansion request and key_valid tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_key    <= '0;
         core_mode   <= 2'b00;
         key_valid   <= 1'b0;
         core_keygen <= 1'b0;
      end else begin
         if (key_go) begin
            core_key  <= key;
            core_mode <= key_mode;
            key_valid <= 1'b0;
         end
         if (state_q == KEYGEN && core_ready) core_keygen <= 1'b1;
         if (state_q == KWAIT && done_ok) begin
            key_valid   <= 1'b1;
            core_keygen <= 1'b0;
         end
      end
   end

   // Block capture and core launch; core_in/core_enc hold until the next LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_reg   <= '0;
         enc_reg  <= 1'b0;
         core_in  <= '0;
         core_enc <= 1'b0;
         core_run <= 1'b0;
      end else begin
         core_run <= kick;
         if (accept) begin
            in_reg  <= s_data;
            enc_reg <= enc;
         end
         if (state_q == LOAD && core_ready) begin
            core_enc <= enc_reg;
`ifdef AES_CBC_CTRL_CBC_EN
            core_in  <= enc_reg ? (in_reg ^ chain) : in_reg;
`else
            core_in  <= in_reg;
`endif
         end
      end
   end

`ifdef AES_CBC_CTRL_CBC_EN
   // Chain register: IV on load, then the last ciphertext block either way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        chain <= '0;
      else if (iv_go)                    chain <= iv;
      else if (state_q == CWAIT && done_ok) chain <= enc_reg ? core_out : in_reg;
   end
`endif

   // Result capture and output hold until the host takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (state_q == CWAIT && done_ok) begin
         m_valid <= 1'b1;
`ifdef AES_CBC_CTRL_CBC_EN
         m_data  <= enc_reg ? core_out : (core_out ^ chain);
`else
         m_data  <= core_out;
`endif
      end else if (state_q == OUT && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Bench for aes_cbc_ctrl: table-backed stand-in for the AES core, directed
// host sequence, expected-output queue popped on each output transfer.
module tb_aes_cbc_ctrl;

   localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] X1     = 128'h6bc0bce12a459991e134741a7f9e1925;
   localparam logic [127:0] X2     = 128'hd86421fb9f1a1eda505ee1375746972c;
   localparam logic [127:0] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] C2     = 128'h5086cb9b507219ee95db113a917678b2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] key = '0;
   logic [1:0]   key_mode = 2'b00;
   logic         key_load = 1'b0;
   logic [127:0] iv = '0;
   logic         iv_load = 1'b0;
   logic         enc = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [127:0] s_data = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [127:0] m_data;
   logic [255:0] core_key;
   logic [1:0]   core_mode;
   logic         core_enc;
   logic         core_keygen;
   logic         core_run;
   logic [127:0] core_in;
   logic [127:0] core_out;
   logic         core_ready;
   logic         core_done;
   logic         core_done_q;
   logic         stray_done = 1'b0;
   logic         key_valid;
   logic         busy;
   logic [2:0]   state_dbg;

   int checks = 0;
   int errors = 0;
   int run_cnt = 0;
   logic [127:0] exp_q[$];
   logic [255:0] mdl_key = '0;
   logic [127:0] mdl_chain = '0;

   assign core_done = core_done_q | stray_done;

   aes_cbc_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .key(key), .key_mode(key_mode), .key_load(key_load),
      .iv(iv), .iv_load(iv_load), .enc(enc),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .core_key(core_key), .core_mode(core_mode), .core_enc(core_enc),
      .core_keygen(core_keygen), .core_run(core_run), .core_in(core_in),
      .core_out(core_out), .core_ready(core_ready), .core_done(core_done),
      .key_valid(key_valid), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // AES stand-in: real answers for the known vectors, an invertible toy
   // permutation for everything else.
   function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                            input logic e);
      logic [127:0] tk [3];
      logic [127:0] tp [3];
      logic [127:0] tc [3];
      logic [127:0] t;
      tk[0] = K1; tp[0] = FIPS_P; tc[0] = FIPS_C;
      tk[1] = K2; tp[1] = X1;     tc[1] = C1;
      tk[2] = K2; tp[2] = X2;     tc[2] = C2;
      for (int i = 0; i < 3; i++) begin
         if (k == tk[i]) begin
            if (e && d == tp[i])  return tc[i];
            if (!e && d == tc[i]) return tp[i];
         end
      end
      if (e) return {d[114:0], d[127:115]} ^ k;
      t = d ^ k;
      return {t[12:0], t[127:13]};
   endfunction

   // ---------------- core model ----------------
   logic         mdl_active;
   int unsigned  mdl_cnt;
   logic [127:0] cap_in;
   logic         cap_enc;
   logic [255:0] cap_key;
   logic [1:0]   cap_mode;
   logic         cap_keygen;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_active  <= 1'b0;
         mdl_cnt     <= 0;
         core_ready  <= 1'b1;
         core_done_q <= 1'b0;
         core_out    <= '0;
      end else begin
         core_done_q <= 1'b0;
         if (mdl_active) begin
            if (mdl_cnt == 0) begin
               mdl_active  <= 1'b0;
               core_ready  <= 1'b1;
               core_done_q <= 1'b1;
               core_out    <= cap_keygen ? 128'h0 : core_fn(cap_key[255:128], cap_in, cap_enc);
            end else begin
               mdl_cnt <= mdl_cnt - 1;
            end
         end else if (core_run) begin
            mdl_active <= 1'b1;
            core_ready <= 1'b0;
            mdl_cnt    <= $urandom_range(3, 0);
            cap_in     <= core_in;
            cap_enc    <= core_enc;
            cap_key    <= core_key;
            cap_mode   <= core_mode;
            cap_keygen <= core_keygen;
         end
      end
   end

   // ---------------- scoreboard / monitors ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL out_unexpected: observed %h expected no output", m_data);
            end
            if (exp_q.size() > 0) chk("m_data", m_data, exp_q.pop_front());
         end
         if (mdl_active) begin
            chk("core_in_hold",   core_in,   cap_in);
            chk("core_enc_hold",  core_enc,  cap_enc);
            chk("core_key_hold",  core_key,  cap_key);
            chk("core_mode_hold", core_mode, cap_mode);
            chk("run_single",     core_run,  0);
         end
         if (core_run) run_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         if (!busy && exp_q.size() == 0) break;
         tick();
      end
      chk("drain_idle", {busy, exp_q.size() == 0}, 2'b01);
   endtask

   task automatic load_key(input logic [255:0] k, input logic [1:0] md,
                           input logic do_iv, input logic [127:0] v);
      wait_drain();
      key = k; key_mode = md; key_load = 1'b1; iv = v; iv_load = do_iv;
      mdl_key = k;
      if (do_iv) mdl_chain = v;
      tick();
      key_load = 1'b0; iv_load = 1'b0;
      chk("key_valid_clr", key_valid, 0);
      chk("keygen_busy", busy, 1);
      for (int i = 0; i < 50 && !key_valid; i++) tick();
      chk("key_valid_set", key_valid, 1);
      chk("core_key", core_key, k);
      chk("core_mode", core_mode, md);
   endtask

   task automatic load_iv(input logic [127:0] v);
      wait_drain();
      iv = v; iv_load = 1'b1;
      mdl_chain = v;
      tick();
      iv_load = 1'b0;
   endtask

   // Offer one block; on acceptance optionally push its expected result.
   task automatic send(input logic [127:0] d, input logic e, input logic push,
                       input logic use_lit, input logic [127:0] lit);
      logic [127:0] r;
      logic got;
      got = 1'b0;
      s_valid = 1'b1; s_data = d; enc = e;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (s_ready) begin got = 1'b1; break; end
      end
      chk("accept", got, 1);
`ifdef AES_CBC_CTRL_CBC_EN
      if (e) begin
         r = core_fn(mdl_key[255:128], d ^ mdl_chain, 1'b1);
         mdl_chain = r;
      end else begin
         r = core_fn(mdl_key[255:128], d, 1'b0) ^ mdl_chain;
         mdl_chain = d;
      end
`else
      r = core_fn(mdl_key[255:128], d, e);
`endif
      if (push && got) exp_q.push_back(use_lit ? lit : r);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_key_valid"},   key_valid,   0);
      chk({tag, "_busy"},        busy,        0);
      chk({tag, "_s_ready"},     s_ready,     0);
      chk({tag, "_m_valid"},     m_valid,     0);
      chk({tag, "_core_run"},    core_run,    0);
      chk({tag, "_core_keygen"}, core_keygen, 0);
      chk({tag, "_m_data"},      m_data,      0);
      chk({tag, "_core_in"},     core_in,     0);
      chk({tag, "_core_key"},    core_key,    0);
      chk({tag, "_core_mode"},   core_mode,   0);
      chk({tag, "_core_enc"},    core_enc,    0);
   endtask

   task automatic wait_m_valid();
      for (int i = 0; i < 100 && !m_valid; i++) tick();
      chk("m_valid_wait", m_valid, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] snap;
      logic [127:0] rd;
      logic [255:0] rk;
      int           runs0;

      // reset
      repeat (3) tick();
      check_reset("por");
      rst_n = 1'b1;
      tick();

      // no key yet: a block must not be accepted
      s_valid = 1'b1; s_data = FIPS_P; enc = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("nokey_s_ready", s_ready, 0);
      end
      chk("nokey_busy", busy, 0);
      chk("nokey_runs", run_cnt, 0);
      tick();
      s_valid = 1'b0;

      // FIPS-197 vector, key and IV loaded together
      load_key({K1, 128'h0}, 2'b00, 1'b1, 128'h0);
      send(FIPS_P, 1'b1, 1'b1, 1'b1, FIPS_C);

      // stray core_done while idle changes nothing
      wait_drain();
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      tick();
      chk("stray_busy", busy, 0);
      chk("stray_m_valid", m_valid, 0);
      chk("stray_key_valid", key_valid, 1);

      // SP800-38A CBC-AES128 encrypt, then decrypt after a fresh IV
      load_key({K2, 128'h0}, 2'b00, 1'b0, 128'h0);
      load_iv(IV);
`ifdef AES_CBC_CTRL_CBC_EN
      send(P1, 1'b1, 1'b1, 1'b1, C1);
      send(P2, 1'b1, 1'b1, 1'b1, C2);
      load_iv(IV);
      send(C1, 1'b0, 1'b1, 1'b1, P1);
      send(C2, 1'b0, 1'b1, 1'b1, P2);
`else
      send(P1, 1'b1, 1'b1, 1'b0, '0);
      send(P2, 1'b1, 1'b1, 1'b0, '0);
      load_iv(IV);
      send(C1, 1'b0, 1'b1, 1'b0, '0);
      send(C2, 1'b0, 1'b1, 1'b0, '0);
`endif

      // backpressure: output held for 10 cycles
      wait_drain();
      m_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0);
      wait_m_valid();
      @(negedge clk);
      snap  = m_data;
      runs0 = run_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_m_valid", m_valid, 1);
         chk("bp_m_data", m_data, snap);
         chk("bp_s_ready", s_ready, 0);
         chk("bp_runs", run_cnt, runs0);
      end
      tick();
      m_ready = 1'b1;

      // key_load / iv_load while busy are ignored
      wait_drain();
      m_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0);
      wait_m_valid();
      key = ~mdl_key; key_mode = 2'b10; key_load = 1'b1;
      iv = {$urandom, $urandom, $urandom, $urandom}; iv_load = 1'b1;
      tick();
      tick();
      key_load = 1'b0; iv_load = 1'b0;
      chk("busy_kv", key_valid, 1);
      chk("busy_core_key", core_key, mdl_key);
      chk("busy_core_mode", core_mode, 2'b00);
      chk("busy_hold", {busy, m_valid}, 2'b11);
      m_ready = 1'b1;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, '0);
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0, '0);

      // 256-bit key, random blocks, random enc and output stalls
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load_key(rk, 2'b10, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      for (int n = 0; n < 14; n++) begin
         send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)),
              1'b1, 1'b0, '0);
         m_ready = 1'($urandom_range(1, 0));
         repeat ($urandom_range(4, 0)) tick();
         m_ready = 1'b1;
      end

      // reset in the middle of a core operation
      wait_drain();
      rd = {$urandom, $urandom, $urandom, $urandom};
      send(rd, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 50 && !mdl_active; i++) tick();
      chk("mid_cwait", {mdl_active, busy}, 2'b11);
      rst_n = 1'b0;
      #1;
      check_reset("mid");
      tick();
      check_reset("mid_next");
      mdl_chain = '0;
      rst_n = 1'b1;
      tick();
      runs0 = run_cnt;
      s_valid = 1'b1; s_data = rd; enc = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_s_ready", s_ready, 0);
         chk("post_rst_busy", busy, 0);
      end
      chk("post_rst_runs", run_cnt, runs0);
      tick();
      s_valid = 1'b0;
      load_key({K1, 128'h0}, 2'b00, 1'b0, 128'h0);
      send(FIPS_P, 1'b1, 1'b1, 1'b1, FIPS_C);

      wait_drain();
      chk("final_queue", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_cbc_ctrl.md
AES_CBC_CTRL -- requirements
Module: aes_cbc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have host ports:
- key: input, 256 bits; 128-bit keys left-aligned in key[255:128].
- key_mode: input, 2 bits; 00=128, 01=192, 10=256.
- key_load: input, 1 bit; key-setup request pulse.
- iv: input, 128 bits.
- iv_load: input, 1 bit; chain-register load pulse.
- enc: input, 1 bit; 1=encrypt, 0=decrypt.
REQ-004 SHALL have input stream ports: s_valid (input, 1), s_ready (output, 1), s_data (input, 128).
REQ-005 SHALL have output stream ports: m_valid (output, 1), m_ready (input, 1), m_data (output, 128).
REQ-006 SHALL have core ports:
- core_key (output, 256), core_mode (output, 2), core_enc (output, 1), core_keygen (output, 1), core_run (output, 1), core_in (output, 128).
- core_out (input, 128), core_ready (input, 1), core_done (input, 1).
REQ-007 SHALL have status outputs key_valid (1 bit) and busy (1 bit).

Function
REQ-008 SHALL implement FSM states IDLE, KEYGEN, KWAIT, LOAD, CWAIT, OUT.
REQ-009 SHALL, on key_load in IDLE: register key/key_mode into core_key/core_mode, clear key_valid, go to KEYGEN.
REQ-010 SHALL, in KEYGEN with core_ready=1: drive core_keygen=1 and core_run=1 for exactly one cycle, then go to KWAIT.
REQ-011 SHALL, in KWAIT on core_done: set key_valid=1, deassert core_keygen, return to IDLE.
REQ-012 SHALL, on iv_load in IDLE: load chain register with iv; if iv_load and key_load coincide, both SHALL be performed.
REQ-013 SHALL ignore key_load and iv_load outside IDLE, with no state change.
REQ-014 SHALL drive s_ready=1 only in IDLE with key_valid=1 and no key_load/iv_load in the same cycle.
REQ-015 SHALL, on s_valid&&s_ready: latch s_data into in_reg and enc into enc_reg, go to LOAD.
REQ-016 SHALL, in LOAD with core_ready=1, pulse core_run for one cycle with:
- core_enc=enc_reg;
- core_in = in_reg^chain when encrypting, in_reg when decrypting;
then go to CWAIT.
REQ-017 SHALL hold core_in, core_enc, core_key and core_mode stable from core_run until core_done.
REQ-018 SHALL, in CWAIT on core_done, capture the result:
- encrypt: m_data=core_out, chain<=core_out;
- decrypt: m_data=core_out^chain, chain<=in_reg;
then set m_valid=1 and go to OUT.
REQ-019 SHALL hold m_valid and m_data stable until m_ready; on m_valid&&m_ready SHALL clear m_valid and return to IDLE; m_ready without m_valid SHALL have no effect.
REQ-020 SHALL ignore core_done outside KWAIT/CWAIT.
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL have minimum latency of 3 cycles from accept to the core_run pulse plus core time plus 1 cycle to m_valid; back-to-back throughput SHALL be one block per core operation plus 3 cycles.
REQ-023 SHALL persist the chain register across blocks until iv_load or reset; an enc change between blocks SHALL NOT reset the chain.

Reset
REQ-024 SHALL, on rst_n=0 in any state (including mid-operation):
- FSM to IDLE;
- key_valid, busy, s_ready, m_valid, core_run and core_keygen to 0;
- m_data, core_in, core_key, chain and in_reg to 0;
- core_mode to 00, core_enc to 0.
REQ-025 SHALL, after reset, require key_load before any block is accepted.

Configuration
REQ-026 SHALL use macro AES_CBC_CTRL_CBC_EN; when defined, chaining per REQ-016/REQ-018 SHALL apply.
REQ-027 SHALL, when AES_CBC_CTRL_CBC_EN is undefined, operate in ECB:
- core_in=in_reg, m_data=core_out;
- chain register absent; iv and iv_load ignored;
- all other behaviour identical.

Verification
REQ-028 SHALL cover FIPS-197 ECB/CBC with IV=0: key 000102030405060708090a0b0c0d0e0f, mode 00, enc=1, s_data 00112233445566778899aabbccddeeff -> m_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-029 SHALL cover SP800-38A CBC-AES128 encrypt: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102...0f, P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d; P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
REQ-030 SHALL cover CBC decrypt of the same two ciphertexts after iv_load -> both plaintexts recovered in order.
REQ-031 SHALL cover backpressure: m_ready held 0 for 10 cycles -> m_valid and m_data stable, s_ready=0, no second core_run.
REQ-032 SHALL cover reset mid-operation: rst_n low during CWAIT -> all REQ-024 values next cycle, key_valid=0, and a later s_valid is not accepted until key_load completes.
REQ-033 SHALL cover key_load and iv_load asserted while busy=1 -> ignored; key_valid and chain unchanged.
